// File: rtl/booth_mult_sequencer.sv
// Booth multiplier sequencer: arbitrates two requesters onto one registered
// multiplier datapath, steps it through load / settle / capture, and returns
// the product with the owning requester's id under a valid/ready handshake.
module booth_mult_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_mcand,
    input  logic [WIDTH-1:0]     req0_mplier,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_mcand,
    input  logic [WIDTH-1:0]     req1_mplier,
    input  logic                 abort,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_product,
    output logic [WIDTH-1:0]     dp_mcand,
    output logic [WIDTH-1:0]     dp_mplier,
    output logic                 dp_enable_a,
    output logic                 dp_enable_b,
    output logic                 dp_enable_out,
    output logic                 dp_reset_a,
    output logic                 dp_reset_b,
    output logic                 dp_reset_out,
    input  logic [2*WIDTH-1:0]   dp_product
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    // Settle counter preload; the Booth array gets MULT_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MULT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             grant_vld;
    logic             grant_id;

    // Arbitration and next-state: abort overrides every handshake and
    // forces a datapath clear via INIT, keeping the round-robin pointer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        grant_vld = 1'b0;
        grant_id  = 1'b0;

        if (state_q == S_IDLE && !abort && (req0_valid || req1_valid)) begin
            grant_vld = 1'b1;
            grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        end

        case (state_q)
            S_INIT:    state_d = S_IDLE;
            S_IDLE: begin
                if (grant_vld) begin
                    state_d  = S_COMPUTE;
                    cnt_d    = CNT_LOAD;
                    id_d     = grant_id;
                    last_d   = grant_id;
                    mcand_d  = grant_id ? req1_mcand  : req0_mcand;
                    mplier_d = grant_id ? req1_mplier : req0_mplier;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == 4'd0) state_d = S_CAPTURE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    if (resp_valid && resp_ready) state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase

        if (abort && state_q != S_INIT) state_d = S_INIT;
    end

    // State and operand-hold registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            id_q     <= id_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Operand buses follow the granted requester in the grant cycle and
    // otherwise hold the last loaded pair.
    assign req0_ready    = grant_vld && !grant_id;
    assign req1_ready    = grant_vld &&  grant_id;
    assign dp_mcand      = mcand_d;
    assign dp_mplier     = mplier_d;
    assign dp_enable_a   = grant_vld;
    assign dp_enable_b   = grant_vld;
    assign dp_enable_out = (state_q == S_CAPTURE) && !abort;
    assign dp_reset_a    = (state_q == S_INIT);
    assign dp_reset_b    = (state_q == S_INIT);
    assign dp_reset_out  = (state_q == S_INIT);
    assign resp_valid    = (state_q == S_RESP) && !abort;
    assign resp_id       = id_q;
    assign resp_product  = dp_product;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: a behavioural datapath closes the loop,
// a scoreboard queue holds expected {id, product, due cycle} per grant.
module tb_booth_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instance with MULT_CYCLES=1 ----------------
    logic        req0_valid = 0, req1_valid = 0, abort = 0, resp_ready = 1;
    logic [31:0] req0_mcand = 0, req0_mplier = 0, req1_mcand = 0, req1_mplier = 0;
    logic        req0_ready, req1_ready, resp_valid, resp_id;
    logic [63:0] resp_product, dp_product;
    logic [31:0] dp_mcand, dp_mplier;
    logic        dp_enable_a, dp_enable_b, dp_enable_out, dp_reset_a, dp_reset_b, dp_reset_out;

    booth_mult_sequencer #(.WIDTH(32), .MULT_CYCLES(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mcand(req0_mcand), .req0_mplier(req0_mplier),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mcand(req1_mcand), .req1_mplier(req1_mplier),
        .abort(abort), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .dp_mcand(dp_mcand), .dp_mplier(dp_mplier),
        .dp_enable_a(dp_enable_a), .dp_enable_b(dp_enable_b), .dp_enable_out(dp_enable_out),
        .dp_reset_a(dp_reset_a), .dp_reset_b(dp_reset_b), .dp_reset_out(dp_reset_out),
        .dp_product(dp_product)
    );

    // Behavioural datapath: two operand registers and a product register.
    logic [31:0] ra, rb;
    always @(posedge clk) begin
        if (dp_reset_a) ra <= '0; else if (dp_enable_a) ra <= dp_mcand;
        if (dp_reset_b) rb <= '0; else if (dp_enable_b) rb <= dp_mplier;
        if (dp_reset_out) dp_product <= '0;
        else if (dp_enable_out) dp_product <= {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
    end

    // ---------------- instance with MULT_CYCLES=3 ----------------
    logic        m3_r0v = 0, m3_r1v = 0, m3_abort = 0, m3_rr = 1;
    logic [31:0] m3_a = 0, m3_b = 0, m3_zero = 0;
    logic        m3_r0rdy, m3_r1rdy, m3_rv, m3_rid;
    logic [63:0] m3_rp, m3_dpp;
    logic [31:0] m3_dpa, m3_dpb;
    logic        m3_ena, m3_enb, m3_eno, m3_rsa, m3_rsb, m3_rso;

    booth_mult_sequencer #(.WIDTH(32), .MULT_CYCLES(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(m3_r0v), .req0_ready(m3_r0rdy), .req0_mcand(m3_a), .req0_mplier(m3_b),
        .req1_valid(m3_r1v), .req1_ready(m3_r1rdy), .req1_mcand(m3_zero), .req1_mplier(m3_zero),
        .abort(m3_abort), .resp_valid(m3_rv), .resp_ready(m3_rr), .resp_id(m3_rid),
        .resp_product(m3_rp), .dp_mcand(m3_dpa), .dp_mplier(m3_dpb),
        .dp_enable_a(m3_ena), .dp_enable_b(m3_enb), .dp_enable_out(m3_eno),
        .dp_reset_a(m3_rsa), .dp_reset_b(m3_rsb), .dp_reset_out(m3_rso),
        .dp_product(m3_dpp)
    );

    logic [31:0] m3_ra, m3_rb;
    always @(posedge clk) begin
        if (m3_rsa) m3_ra <= '0; else if (m3_ena) m3_ra <= m3_dpa;
        if (m3_rsb) m3_rb <= '0; else if (m3_enb) m3_rb <= m3_dpb;
        if (m3_rso) m3_dpp <= '0;
        else if (m3_eno) m3_dpp <= {{32{m3_ra[31]}}, m3_ra} * {{32{m3_rb[31]}}, m3_rb};
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic id; logic [63:0] prod; int due; } exp_t;
    exp_t sb[$];

    typedef struct { logic r; logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;
    vec_t tbl [8];

    logic rv_prev = 1'b0;
    logic exp_last = 1'b1;

    // Response monitor: latency on the rising edge of resp_valid, id and
    // product on each completed handshake.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && !rv_prev) begin
            if (sb.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
            else                chk("resp_latency", 64'(cyc), 64'(sb[0].due));
        end
        if (resp_valid && resp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_product", resp_product, e.prod);
        end
        rv_prev = resp_valid;
    end

    // Present one operand pair on requester r and wait for its grant.
    task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        bit got = 0;
        if (r) begin req1_valid = 1; req1_mcand = a; req1_mplier = b; end
        else   begin req0_valid = 1; req0_mcand = a; req0_mplier = b; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (r ? req1_ready : req0_ready) begin
                got = 1;
                chk("grant_enable_ab", 64'({dp_enable_a, dp_enable_b}), 64'd3);
                chk("grant_dp_mcand", 64'(dp_mcand), 64'(a));
                chk("grant_dp_mplier", 64'(dp_mplier), 64'(b));
                sb.push_back('{r, p, cyc + 3});
                exp_last = r;
            end
            @(posedge clk); #1;
        end
        if (!got) chk("grant_timeout", 64'd0, 64'd1);
        req0_valid = 0;
        req1_valid = 0;
        @(negedge clk);
        chk("ready_pulse", 64'({req0_ready, req1_ready, dp_enable_a, dp_enable_b}), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n;
        logic expg;

        tbl[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1] = '{1'b1, 32'h7FFF_FFFF,  32'd2,         64'h0000_0000_FFFF_FFFE};
        tbl[2] = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[4] = '{1'b0, 32'd0,          32'h1234_5678, 64'h0000_0000_0000_0000};
        tbl[5] = '{1'b1, 32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
        tbl[6] = '{1'b0, 32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        tbl[7] = '{1'b1, 32'd100,        32'd200,       64'h0000_0000_0000_4E20};

        // Reset: requests present but must not be accepted.
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(negedge clk);
        chk("rst_dp_reset", 64'({dp_reset_a, dp_reset_b, dp_reset_out}), 64'd7);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_resp", 64'({resp_valid, resp_id}), 64'd0);
        chk("rst_dp_enable", 64'({dp_enable_a, dp_enable_b, dp_enable_out}), 64'd0);
        chk("rst_dp_operands", {dp_mcand, dp_mplier}, 64'd0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        chk("init_dp_reset", 64'({dp_reset_a, dp_reset_b, dp_reset_out}), 64'd7);
        @(negedge clk);
        chk("idle_dp_reset", 64'({dp_reset_a, dp_reset_b, dp_reset_out}), 64'd0);
        chk("idle_ready", 64'({req0_ready, req1_ready, resp_valid}), 64'd0);
        @(posedge clk); #1;

        // Table of single operations.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].p);
            drain();
        end

        // Contention: both valid, grants must alternate starting away from last grant.
        req0_valid = 1; req0_mcand = 32'd5;          req0_mplier = 32'd6;
        req1_valid = 1; req1_mcand = 32'hFFFF_FFFC; req1_mplier = 32'd9;
        expg = ~exp_last;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("rr_onehot", 64'(req0_ready & req1_ready), 64'd0);
                chk("rr_grant", 64'(req1_ready), 64'(expg));
                sb.push_back('{req1_ready, req1_ready ? 64'hFFFF_FFFF_FFFF_FFDC : 64'd30, cyc + 3});
                expg = ~expg;
                n++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_count", 64'(n), 64'd4);
        drain();

        // Back-pressure: response and product must hold, no new grant.
        resp_ready = 0;
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        req1_valid = 1; req1_mcand = 32'd3; req1_mplier = 32'd3;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (resp_valid) seen = 1; else @(negedge clk);
        end
        chk("bp_resp_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(resp_valid), 64'd1);
            chk("bp_product_hold", resp_product, 64'h4000_0000_0000_0000);
            chk("bp_ready_low", 64'({req0_ready, req1_ready}), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1; req1_valid = 0;
        drain();

        // Abort during COMPUTE: datapath cleared, no response.
        issue(1'b0, 32'd11, 32'd13, 64'd143);
        abort = 1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_dp_reset", 64'({dp_reset_a, dp_reset_b, dp_reset_out}), 64'd7);
        chk("abort_resp_low", 64'(resp_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid || dp_reset_a) seen = 1;
        end
        chk("abort_no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        issue(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        drain();

        // MULT_CYCLES=3 instance: resp_valid rises 5 cycles after the handshake.
        m3_r0v = 1; m3_a = 32'h7FFF_FFFF; m3_b = 32'd2;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (m3_r0rdy) seen = 1;
            @(posedge clk); #1;
        end
        chk("m3_grant", 64'(seen), 64'd1);
        m3_r0v = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("m3_valid_k%0d", k), 64'(m3_rv), 64'(k == 5));
        end
        chk("m3_product", m3_rp, 64'h0000_0000_FFFF_FFFE);
        chk("m3_id", 64'(m3_rid), 64'd0);
        repeat (2) @(negedge clk);
        chk("m3_resp_done", 64'(m3_rv), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
